sdram_cmd_arbiter: RTL

//  Shares the SDRAM command/address/DQ pins among the init, auto-refresh, write and read engines inside sdram_top.

---
 rtl/sdram_cmd_arbiter_pkg.sv | 36 +++
 rtl/sdram_cmd_arbiter_pick.sv | 35 +++
 rtl/sdram_cmd_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sdram_cmd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_cmd_arbiter_pkg
//  Description : Shared types and SDRAM command encodings for the
//                command/address/DQ pin arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package sdram_cmd_arbiter_pkg;

   // Arbiter states; the pins belong to exactly one owner per state
   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_ARB   = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } state_t;

   // {CSn,RASn,CASn,WEn}
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_RD   = 4'b0101;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_MRS  = 4'b0000;

   // One-hot grant produced by the picker
   typedef struct packed {
      logic aref;
      logic wr;
      logic rd;
   } grant_t;

endpackage
`default_nettype wire

// File: rtl/sdram_cmd_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_arb_pick
//  Description : Combinational request picker. Refresh always wins; when
//                write and read collide, last_wr selects read (so a constant
//                0 gives fixed write priority).
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_arb_pick
   import sdram_cmd_arbiter_pkg::*;
(
   input  logic   aref_req,
   input  logic   wr_req,
   input  logic   rd_req,
   input  logic   last_wr,
   output grant_t grant
);

   // Priority pick producing at most one grant bit
   always_comb begin
      grant = '0;
      if (aref_req) begin
         grant.aref = 1'b1;
      end else if (wr_req && rd_req) begin
         if (last_wr) grant.rd = 1'b1;
         else         grant.wr = 1'b1;
      end else if (wr_req) begin
         grant.wr = 1'b1;
      end else if (rd_req) begin
         grant.rd = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sdram_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_cmd_arbiter
//  Description : Shares SDRAM command/bank/address/DQ pins between the init,
//                auto-refresh, write and read engines. All pin outputs are
//                registered. Build option ROUND_ROBIN_EN alternates write and
//                read on contention; otherwise write beats read.
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_cmd_arbiter
   import sdram_cmd_arbiter_pkg::*;
#(
   parameter int ADDR_W = 13,
   parameter int BA_W   = 2,
   parameter int DQ_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_done,
   input  logic [3:0]        init_cmd,
   input  logic [BA_W-1:0]   init_ba,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              aref_req,
   output logic              aref_en,
   input  logic              aref_end,
   input  logic [3:0]        aref_cmd,
   input  logic [BA_W-1:0]   aref_ba,
   input  logic [ADDR_W-1:0] aref_addr,
   input  logic              wr_req,
   output logic              wr_en,
   input  logic              wr_end,
   input  logic [3:0]        wr_cmd,
   input  logic [BA_W-1:0]   wr_ba,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DQ_W-1:0]   wr_dq,
   input  logic              wr_dq_oe,
   input  logic              rd_req,
   output logic              rd_en,
   input  logic              rd_end,
   input  logic [3:0]        rd_cmd,
   input  logic [BA_W-1:0]   rd_ba,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              aref_pend,
   output logic [3:0]        sdram_cmd,
   output logic [BA_W-1:0]   sdram_ba,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [DQ_W-1:0]   sdram_dq,
   output logic              sdram_oe
);

   state_t              state_q, state_d;
   logic [3:0]          cmd_q, cmd_d;
   logic [BA_W-1:0]     ba_q, ba_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DQ_W-1:0]     dq_q, dq_d;
   logic                oe_q, oe_d;
   logic                aref_pend_q, aref_pend_d;
   logic                last_wr_sel;
   grant_t              grant;

`ifdef ROUND_ROBIN_EN
   logic                last_wr_q, last_wr_d;
   assign last_wr_sel = last_wr_q;
`else
   // Without round-robin the picker always sees "read served last"
   assign last_wr_sel = 1'b0;
`endif

   sdram_arb_pick u_pick (
      .aref_req (aref_req),
      .wr_req   (wr_req),
      .rd_req   (rd_req),
      .last_wr  (last_wr_sel),
      .grant    (grant)
   );

   // Next state and next pin values; pins reflect the current owner's inputs
   always_comb begin
      state_d     = state_q;
      cmd_d       = CMD_NOP;
      ba_d        = '0;
      addr_d      = '0;
      dq_d        = '0;
      oe_d        = 1'b0;
      aref_pend_d = 1'b0;
`ifdef ROUND_ROBIN_EN
      last_wr_d   = last_wr_q;
`endif
      case (state_q)
         ST_INIT: begin
            cmd_d  = init_cmd;
            ba_d   = init_ba;
            addr_d = init_addr;
            if (init_done) state_d = ST_ARB;
         end
         ST_ARB: begin
            if (grant.aref) begin
               state_d = ST_AREF;
            end else if (grant.wr) begin
               state_d = ST_WRITE;
`ifdef ROUND_ROBIN_EN
               last_wr_d = 1'b1;
`endif
            end else if (grant.rd) begin
               state_d = ST_READ;
`ifdef ROUND_ROBIN_EN
               last_wr_d = 1'b0;
`endif
            end
         end
         ST_AREF: begin
            cmd_d  = aref_cmd;
            ba_d   = aref_ba;
            addr_d = aref_addr;
            if (aref_end) state_d = ST_ARB;
         end
         ST_WRITE: begin
            cmd_d  = wr_cmd;
            ba_d   = wr_ba;
            addr_d = wr_addr;
            dq_d   = wr_dq;
            oe_d   = wr_dq_oe;
            if (wr_end) state_d = ST_ARB;
            else        aref_pend_d = aref_pend_q | aref_req;
         end
         ST_READ: begin
            cmd_d  = rd_cmd;
            ba_d   = rd_ba;
            addr_d = rd_addr;
            if (rd_end) state_d = ST_ARB;
            else        aref_pend_d = aref_pend_q | aref_req;
         end
         default: state_d = ST_INIT;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_INIT;
         cmd_q       <= CMD_NOP;
         ba_q        <= '0;
         addr_q      <= '0;
         dq_q        <= '0;
         oe_q        <= 1'b0;
         aref_pend_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
         last_wr_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         ba_q        <= ba_d;
         addr_q      <= addr_d;
         dq_q        <= dq_d;
         oe_q        <= oe_d;
         aref_pend_q <= aref_pend_d;
`ifdef ROUND_ROBIN_EN
         last_wr_q   <= last_wr_d;
`endif
      end
   end

   // Grants decode straight from the state register, so they are one-hot
   assign aref_en    = (state_q == ST_AREF);
   assign wr_en      = (state_q == ST_WRITE);
   assign rd_en      = (state_q == ST_READ);
   assign aref_pend  = aref_pend_q;
   assign sdram_cmd  = cmd_q;
   assign sdram_ba   = ba_q;
   assign sdram_addr = addr_q;
   assign sdram_dq   = dq_q;
   assign sdram_oe   = oe_q;

endmodule
`default_nettype wire
